// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS sequencer.
// master = controller (drives strobes), slave = datapath (drives opcode/flags).
interface mips_multicycle_ctrl_if #(
    parameter int RET_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             halted;
    logic [RET_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, halted, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, halted, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer with retired-instruction counter.
// Optional macro MC_ILLEGAL_TRAP_EN: unrecognized opcodes halt instead of acting as NOPs.
module mips_multicycle_ctrl #(
    parameter int RET_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [RET_W-1:0] W_ONE = {{(RET_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [RET_W-1:0] r_retired;

    // The branch decision lives in the datapath's PC-write-conditional gate.
    logic w_unused_zero;
    assign w_unused_zero = bus.zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_RST:   r_state <= S_FETCH;
                S_FETCH: if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADDR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                            r_state <= S_HALT;
`else
                            r_state   <= S_FETCH;
                            r_retired <= r_retired + W_ONE;
`endif
                        end
                    endcase
                end
                S_MEMADDR: r_state <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + W_ONE;
                    end
                end
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + W_ONE;
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                // Latch IR and advance PC only on the cycle memory delivers.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADDR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.state   = r_state;
    assign bus.retired = r_retired;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.halted  = (r_state == S_HALT);
`else
    assign bus.halted  = 1'b0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an instruction-level plan model,
// with directed checks for reset, lw, stalled sw, beq/j, illegal opcode and counter wrap.
module tb_mips_multicycle_ctrl;
    localparam int RET_W = 4;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.RET_W(RET_W)) bus ();
    mips_multicycle_ctrl #(.RET_W(RET_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    // Model: current state, the states still ahead for this instruction, retire count.
    int m_state = 0;
    int m_plan[$];
    int m_ret = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_vec(input int s, input bit rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'd0; op = 2'd0; ps = 2'd0;
        case (s)
            1:  begin mr = 1; sb = 2'd1; irw = rdy; pw = rdy; end
            2:  sb = 2'd3;
            3, 11: begin sa = 1; sb = 2'd2; end
            4:  begin mr = 1; iod = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin sa = 1; op = 2'd2; end
            8:  begin rd = 1; rw = 1; end
            9:  begin sa = 1; op = 2'd1; pwc = 1; ps = 2'd1; end
            10: begin pw = 1; ps = 2'd2; end
            12: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    function automatic logic [15:0] act_vec();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_plan.delete();
        m_ret = 0;
    endtask

    task automatic model_advance();
        if (m_plan.size() == 0) begin
            m_ret = (m_ret + 1) % (1 << RET_W);
            m_state = 1;
            $display("retire op=%b retired=%0d", bus.opcode, m_ret);
        end else begin
            m_state = m_plan.pop_front();
        end
    endtask

    task automatic model_step(input bit rdy, input logic [5:0] opc);
        if (!reset) begin
            model_reset();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 13) begin
            m_state = 13;
        end else if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
            m_state = m_state;
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            case (opc)
                OP_LW:   m_plan = '{3, 4, 5};
                OP_SW:   m_plan = '{3, 6};
                OP_R:    m_plan = '{7, 8};
                OP_BEQ:  m_plan = '{9};
                OP_J:    m_plan = '{10};
                OP_ADDI: m_plan = '{11, 12};
`ifdef MC_ILLEGAL_TRAP_EN
                default: m_plan = '{13};
`else
                default: m_plan.delete();
`endif
            endcase
            model_advance();
        end else begin
            model_advance();
        end
    endtask

    // Called at a negedge: drive inputs, compare, then step model on the edge.
    task automatic cycle(input bit rdy);
        logic [5:0] opc;
        bus.mem_ready = rdy;
        bus.zero = 1'($urandom_range(0, 1));
        #1;
        chk("state", int'(bus.state), m_state);
        chk("strobes", int'(act_vec()), int'(exp_vec(m_state, rdy)));
        chk("halted", int'(bus.halted), int'(m_state == 13));
        chk("retired", int'(bus.retired), m_ret);
        opc = bus.opcode;
        @(posedge clk);
        model_step(rdy, opc);
        @(negedge clk);
    endtask

    task automatic reset_seq();
        reset = 1'b0;
        model_reset();
        cycle(1'b1);
        reset = 1'b1;
    endtask

    initial begin : main
        int seq[6];
        int halt_cnt;
        logic [5:0] pick;
        seq = '{1, 2, 3, 4, 5, 1};
        bus.opcode = OP_R;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        @(negedge clk);
        cycle(1'b1);
        cycle(1'b0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_strobes", int'(act_vec()), 0);
        chk("rst_retired", int'(bus.retired), 0);
        reset = 1'b1;

        // lw with memory always ready
        bus.opcode = OP_LW;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1);
            chk("lw_seq", int'(bus.state), seq[i]);
            chk("lw_regwr", int'(bus.reg_write && bus.mem_to_reg), int'(seq[i] == 5));
        end
        chk("lw_retired", int'(bus.retired), 1);

        // sw stalled three cycles in MEMWR
        bus.opcode = OP_SW;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("sw_state", int'(bus.state), 6);
        for (int k = 0; k < 4; k++) begin
            chk("sw_memwr", int'(bus.mem_write), 1);
            chk("sw_ret_hold", int'(bus.retired), 1);
            cycle(k == 3);
        end
        chk("sw_done", int'(bus.state), 1);
        chk("sw_retired", int'(bus.retired), 2);

        // beq then j, three cycles each
        bus.opcode = OP_BEQ;
        cycle(1'b1); cycle(1'b1);
        chk("beq_pwc", int'(bus.pc_write_cond), 1);
        chk("beq_psrc", int'(bus.pc_source), 1);
        cycle(1'b1);
        chk("beq_fetch", int'(bus.state), 1);
        bus.opcode = OP_J;
        cycle(1'b1); cycle(1'b1);
        chk("j_pw", int'(bus.pc_write), 1);
        chk("j_psrc", int'(bus.pc_source), 2);
        cycle(1'b1);
        chk("j_fetch", int'(bus.state), 1);
        chk("bj_retired", int'(bus.retired), 4);

        // illegal opcode
        bus.opcode = OP_BAD;
        cycle(1'b1); cycle(1'b1);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            chk("ill_state", int'(bus.state), 13);
            chk("ill_halted", int'(bus.halted), 1);
            chk("ill_retired", int'(bus.retired), 4);
            cycle(1'($urandom_range(0, 1)));
        end
`else
        chk("ill_state", int'(bus.state), 1);
        chk("ill_retired", int'(bus.retired), 5);
`endif

        // asynchronous reset in the middle of a stalled MEMRD
        reset_seq();
        bus.opcode = OP_LW;
        for (int i = 0; i < 4; i++) cycle(1'b1);
        cycle(1'b0);
        chk("mid_memrd", int'(bus.state), 4);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_strobes", int'(act_vec()), 0);
        chk("arst_retired", int'(bus.retired), 0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1);
        chk("rel_state", int'(bus.state), 1);
        chk("rel_memrd", int'(bus.mem_read), 1);

        // 16 R-type instructions wrap the 4-bit counter
        bus.opcode = OP_R;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 4; c++) cycle(1'b1);
            if (n == 14) chk("wrap_15", int'(bus.retired), 15);
        end
        chk("wrap_0", int'(bus.retired), 0);
        chk("wrap_state", int'(bus.state), 1);

        // random traffic
        halt_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_state == 13) halt_cnt++;
            if (halt_cnt >= 10) begin
                halt_cnt = 0;
                reset_seq();
            end else begin
                if (m_state == 1) begin
                    case ($urandom_range(0, 6))
                        0: pick = OP_LW;
                        1: pick = OP_SW;
                        2: pick = OP_R;
                        3: pick = OP_BEQ;
                        4: pick = OP_J;
                        5: pick = OP_ADDI;
                        default: pick = ($urandom_range(0, 3) == 0) ? OP_BAD : OP_R;
                    endcase
                    bus.opcode = pick;
                end
                cycle($urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore/Mealy control sequencer that drives the CPU datapath (program counter, instruction memory/RAM, register file, ALU and the jump/ALU/register/RAM/branch muxes) in multi-cycle mode. It replaces single-cycle decode. It walks each instruction through fetch, decode, execute, memory and writeback states, stalling on a memory-ready handshake. It also keeps a retired-instruction count for the testbenches.

## Interface
Parameters:
- `RET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction-register bits [31:26].
- `zero`  in  1  ALU zero flag. Used only by the datapath's PC-write-conditional gate; the controller does not branch on it.
- `mem_ready`  in  1  memory access complete this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath strobes/selects.
- `alu_src_b`, `alu_op`, `pc_source`  out  2 each  mux selects / ALU class.
- `state`  out  4  current state encoding (debug).
- `halted`  out  1  controller stopped on illegal opcode.
- `retired`  out  RET_W  instructions completed since reset.

## Operation
- State encoding:
  - RST=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6.
  - EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=13.
  - Codes 14–15 go to RST on the next edge.
- Every output not listed for a state is 0.
- **RST:** all outputs 0 → FETCH.
- **FETCH:**
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are set to `mem_ready` (Mealy).
  - Stay in FETCH while !mem_ready, else → DECODE.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADDR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other → illegal (see Configuration)
- **MEMADDR:** alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD, sw → MEMWR.
- **MEMRD:** mem_read=1, i_or_d=1. Hold until mem_ready → MEMWB.
- **MEMWB:** reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- **MEMWR:** mem_write=1, i_or_d=1. Hold until mem_ready → FETCH.
- **EXEC:** alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- **ALUWB:** reg_dst=1, reg_write=1 → FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- **JUMP:** pc_write=1, pc_source=10 → FETCH.
- **ADDIEX:** alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- **ADDIWB:** reg_dst=0, reg_write=1 → FETCH.
- **HALT:** all strobes 0, halted=1. Sticky until reset.
- **retired counter:**
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, JUMP or ADDIWB.
  - Wraps modulo 2^RET_W with no flag.
  - The RST→FETCH transition is not counted.

## Timing
- Reset asserted (reset=0), asynchronously, at any time including mid-access:
  - state=RST, retired=0, halted=0, all strobes 0.
  - Any stalled access is abandoned.
- First FETCH is the cycle after reset deasserts, on the first rising edge.
- Latency with mem_ready held 1:
  - lw 5 cycles; R-type, sw and addi 4 cycles; beq and j 3 cycles.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Outputs are combinational from `state`; only ir_write/pc_write also depend on mem_ready. No output register stage.
- opcode must be stable from the FETCH completion edge through the end of the instruction. The controller does not latch it.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unrecognized opcode in DECODE → HALT, halted=1.
  - The illegal instruction is not counted in `retired`.
- Undefined:
  - An unrecognized opcode in DECODE → FETCH, treated as a NOP.
  - It is counted in `retired`.
  - HALT is unreachable and halted is tied 0.

## Test plan
- **Reset:** reset=0 mid-MEMRD → next sample shows state=0, all strobes 0, retired=0; release → FETCH with mem_read=1 one edge later.
- **lw with mem_ready=1:** state sequence 1,2,3,4,5,1 → reg_write=1 and mem_to_reg=1 only in state 5; retired becomes 1.
- **Stall:** sw with mem_ready=0 for 3 cycles in MEMWR → mem_write held 1 for 4 cycles; retired increments only on the ready edge.
- **beq then j:** opcodes 000100 then 000010 → pc_write_cond=1 with pc_source=01 in BRANCH; pc_write=1 with pc_source=10 in JUMP; 3 cycles each; retired=2.
- **Illegal opcode 111111:**
  - With MC_ILLEGAL_TRAP_EN: state=13 and halted=1, stuck for 10 cycles, retired unchanged.
  - Without it: returns to FETCH, retired+1.
- **Wrap:** RET_W=4 with 16 R-type instructions → retired returns to 0.
